// File: rtl/bldcm_deadtime.sv
// rtl/bldcm_deadtime.sv - dead-time insertion and shoot-through guard for six BLDC gate drives
module bldcm_deadtime #(
  parameter logic [7:0] pDeadCycles = 8'd50
) (
  input  logic iClock,
  input  logic iReset_n,
  input  logic iEnable,
  input  logic iFaultClear,
  input  logic iUh,
  input  logic iUl,
  input  logic iVh,
  input  logic iVl,
  input  logic iWh,
  input  logic iWl,
  output logic oUh,
  output logic oUl,
  output logic oVh,
  output logic oVl,
  output logic oWh,
  output logic oWl,
  output logic oFault
);

  typedef enum logic [1:0] {
    G_OFF  = 2'd0,
    G_HIGH = 2'd1,
    G_LOW  = 2'd2
  } gate_t;

  // Channel index 0 = U, 1 = V, 2 = W.
  logic [2:0] req_h;
  logic [2:0] req_l;
  logic [2:0] illegal;
  logic       fault_set;
  logic       force_off;

  gate_t      gate [3];
  logic [7:0] cnt  [3];
  gate_t      want [3];

  assign req_h     = {iWh, iVh, iUh};
  assign req_l     = {iWl, iVl, iUl};
  assign illegal   = req_h & req_l;
  assign fault_set = iEnable & (|illegal);

  // A fault being raised this cycle already forces every gate off on the same
  // edge, so no switch is ever left on while the fault flag rises.
  assign force_off = ~iEnable | oFault | fault_set;

  // Decode the effective request per channel; ILLEGAL falls through to OFF.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      want[i] = G_OFF;
      if (!force_off) begin
        if (req_h[i] && !req_l[i]) begin
          want[i] = G_HIGH;
        end else if (req_l[i] && !req_h[i]) begin
          want[i] = G_LOW;
        end
      end
    end
  end

  // Per-channel gate state and saturating dead counter; any change of an active
  // gate goes through OFF and restarts the dead interval.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < 3; i++) begin
        gate[i] <= G_OFF;
        cnt[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (gate[i] != G_OFF) begin
          if (want[i] != gate[i]) begin
            gate[i] <= G_OFF;
            cnt[i]  <= 8'd1;
          end
        end else if (cnt[i] < pDeadCycles) begin
          cnt[i] <= cnt[i] + 8'd1;
        end else if (want[i] != G_OFF) begin
          gate[i] <= want[i];
        end
      end
    end
  end

  // Sticky fault flag; a new set wins over a simultaneous clear.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oFault <= 1'b0;
    end else if (fault_set) begin
      oFault <= 1'b1;
    end else if (iFaultClear) begin
      oFault <= 1'b0;
    end
  end

  assign oUh = (gate[0] == G_HIGH);
  assign oUl = (gate[0] == G_LOW);
  assign oVh = (gate[1] == G_HIGH);
  assign oVl = (gate[1] == G_LOW);
  assign oWh = (gate[2] == G_HIGH);
  assign oWl = (gate[2] == G_LOW);

endmodule

// File: tb/tb_bldcm_deadtime.sv
// tb/tb_bldcm_deadtime.sv - directed vector bench for bldcm_deadtime with pDeadCycles = 4
module tb_bldcm_deadtime;

  logic clk;
  logic rst_n;
  logic en;
  logic clr;
  logic uh, ul, vh, vl, wh, wl;
  logic o_uh, o_ul, o_vh, o_vl, o_wh, o_wl, o_fault;

  int total;
  int bad;

  bldcm_deadtime #(.pDeadCycles(8'd4)) dut (
    .iClock      (clk),
    .iReset_n    (rst_n),
    .iEnable     (en),
    .iFaultClear (clr),
    .iUh         (uh),
    .iUl         (ul),
    .iVh         (vh),
    .iVl         (vl),
    .iWh         (wh),
    .iWl         (wl),
    .oUh         (o_uh),
    .oUl         (o_ul),
    .oVh         (o_vh),
    .oVl         (o_vl),
    .oWh         (o_wh),
    .oWl         (o_wl),
    .oFault      (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req = {uh,ul,vh,vl,wh,wl}; exp = {oUh,oUl,oVh,oVl,oWh,oWl,oFault}
  typedef struct {
    logic       en;
    logic       clr;
    logic [5:0] req;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [19];

  task automatic set_in(input logic e, input logic c, input logic [5:0] r);
    en  = e;
    clr = c;
    {uh, ul, vh, vl, wh, wl} = r;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {o_uh, o_ul, o_vh, o_vl, o_wh, o_wl, o_fault};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply current inputs across one rising edge and sample on the falling edge.
  task automatic step(input string name, input logic [6:0] exp);
    @(posedge clk);
    @(negedge clk);
    check(name, exp);
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 6'b100000);

    tbl[0]  = '{1'b1, 1'b0, 6'b100000, 7'b0000000};
    tbl[1]  = '{1'b1, 1'b0, 6'b100000, 7'b0000000};
    tbl[2]  = '{1'b1, 1'b0, 6'b100000, 7'b0000000};
    tbl[3]  = '{1'b1, 1'b0, 6'b100000, 7'b0000000};
    tbl[4]  = '{1'b1, 1'b0, 6'b100000, 7'b1000000};
    tbl[5]  = '{1'b1, 1'b0, 6'b100000, 7'b1000000};
    tbl[6]  = '{1'b1, 1'b0, 6'b010000, 7'b0000000};
    tbl[7]  = '{1'b1, 1'b0, 6'b010000, 7'b0000000};
    tbl[8]  = '{1'b1, 1'b0, 6'b010000, 7'b0000000};
    tbl[9]  = '{1'b1, 1'b0, 6'b010000, 7'b0000000};
    tbl[10] = '{1'b1, 1'b0, 6'b010000, 7'b0100000};
    tbl[11] = '{1'b1, 1'b0, 6'b010100, 7'b0101000};
    tbl[12] = '{1'b1, 1'b0, 6'b010110, 7'b0101100};
    tbl[13] = '{1'b1, 1'b0, 6'b010110, 7'b0101100};
    tbl[14] = '{1'b0, 1'b0, 6'b010110, 7'b0000000};
    tbl[15] = '{1'b0, 1'b0, 6'b010110, 7'b0000000};
    tbl[16] = '{1'b1, 1'b0, 6'b010110, 7'b0000000};
    tbl[17] = '{1'b1, 1'b0, 6'b010110, 7'b0000000};
    tbl[18] = '{1'b1, 1'b0, 6'b010110, 7'b0101100};

    #12;
    check("reset_state", 7'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Startup wait, HIGH->LOW dead interval, saturated turn-on, enable drop.
    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].en, tbl[i].clr, tbl[i].req);
      step($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Shoot-through request on V while W is driving HIGH.
    do_reset();
    set_in(1'b1, 1'b0, 6'b000010);
    for (int i = 0; i < 4; i++) step("flt_wait", 7'b0);
    step("flt_w_on", 7'b0000100);
    set_in(1'b1, 1'b0, 6'b001110);
    step("flt_set", 7'b0000001);
    set_in(1'b1, 1'b1, 6'b000010);
    step("flt_clear", 7'b0000000);
    set_in(1'b1, 1'b0, 6'b000010);
    step("flt_dead2", 7'b0000000);
    step("flt_dead3", 7'b0000000);
    step("flt_w_back", 7'b0000100);

    // Set and clear in the same cycle: set wins, then a plain clear works.
    set_in(1'b1, 1'b0, 6'b110010);
    step("flt_u_illegal", 7'b0000001);
    set_in(1'b1, 1'b1, 6'b000011);
    step("flt_set_wins", 7'b0000001);
    set_in(1'b1, 1'b1, 6'b000000);
    step("flt_clr_only", 7'b0000000);
    // ILLEGAL while disabled must not raise the fault.
    set_in(1'b0, 1'b0, 6'b110000);
    step("flt_disabled", 7'b0000000);

    // Request flipping every cycle during the dead interval.
    do_reset();
    set_in(1'b1, 1'b0, 6'b100000);
    for (int i = 0; i < 4; i++) step("flip_wait", 7'b0);
    step("flip_u_on", 7'b1000000);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, (i % 2 == 0) ? 6'b010000 : 6'b100000);
      step($sformatf("flip_dead%0d", i), 7'b0);
    end
    set_in(1'b1, 1'b0, 6'b010000);
    step("flip_low_on", 7'b0100000);
    set_in(1'b1, 1'b0, 6'b100000);
    step("flip_off_again", 7'b0000000);

    // Reset in the middle of a dead interval restarts the full wait.
    for (int i = 0; i < 2; i++) step("rst_mid_dead", 7'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step($sformatf("rst_rewait%0d", i), 7'b0);
    step("rst_u_on", 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
